rgb_line_window_ctrl: RTL and testbench

//  Receives the raster RGB pixel stream driven by the image-feed bench: 4 lines up front, then one line per intr pulse.

---
 rtl/rgb_line_window_ctrl.sv | 166 ++++++++++++++++
 tb/tb_rgb_line_window_ctrl.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/rgb_line_window_ctrl.sv
// Line-buffer ring that turns a raster RGB stream into 3x3 windows for the conv engine.
// Four line buffers: three are read while the fourth fills. o_intr asks the feeder for one more line.
module rgb_line_window_ctrl #(
  parameter int unsigned IMG_WIDTH = 416,
  parameter int unsigned PIX_W     = 24
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [PIX_W-1:0]     i_pixel_data,
  input  logic                 i_pixel_valid,
  output logic [9*PIX_W-1:0]   o_window_data,
  output logic                 o_window_valid,
  input  logic                 i_out_ready,
  output logic                 o_intr,
  output logic                 o_overflow
);

  localparam int unsigned NUM_LINES = 4;
  localparam int unsigned LINE_W    = 2;
  localparam int unsigned COL_W     = $clog2(IMG_WIDTH);
  localparam int unsigned CNT_W     = 3;
  localparam int unsigned WIN_W     = 9 * PIX_W;
  localparam logic [COL_W-1:0] LAST_COL = COL_W'(IMG_WIDTH - 1);

  typedef enum logic {S_IDLE, S_READ} state_e;

  logic [PIX_W-1:0] line_mem [NUM_LINES][IMG_WIDTH];

  state_e             state_q, state_d;
  logic [COL_W-1:0]   wr_col_q, wr_col_d;
  logic [LINE_W-1:0]  wr_line_q, wr_line_d;
  logic [COL_W-1:0]   rd_col_q, rd_col_d;
  logic [LINE_W-1:0]  rd_line_q, rd_line_d;
  logic [CNT_W-1:0]   filled_q, filled_d;
  logic [WIN_W-1:0]   win_data_q, win_data_d;
  logic               win_valid_q, win_valid_d;
  logic               intr_q, intr_d;
  logic               overflow_q, overflow_d;

  logic               wr_en;
  logic               line_done_wr;
  logic               line_done_rd;
  logic               advance;
  logic               left_ok, right_ok;
  logic [COL_W-1:0]   left_idx, right_idx;
  logic [WIN_W-1:0]   window_c;

  // Write side: a full ring drops the pixel and latches overflow.
  always_comb begin
    wr_en        = i_pixel_valid && (filled_q != CNT_W'(NUM_LINES));
    line_done_wr = wr_en && (wr_col_q == LAST_COL);
    wr_col_d     = wr_col_q;
    wr_line_d    = wr_line_q;
    overflow_d   = overflow_q | (i_pixel_valid && !wr_en);
    if (wr_en) begin
      if (wr_col_q == LAST_COL) begin
        wr_col_d  = '0;
        wr_line_d = wr_line_q + LINE_W'(1);
      end else begin
        wr_col_d  = wr_col_q + COL_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      line_mem[wr_line_q][wr_col_q] <= i_pixel_data;
    end
  end

  // 3x3 fetch around rd_col with zero padding at both line ends.
  always_comb begin
    left_ok   = (rd_col_q != '0);
    right_ok  = (rd_col_q != LAST_COL);
    left_idx  = left_ok  ? (rd_col_q - COL_W'(1)) : rd_col_q;
    right_idx = right_ok ? (rd_col_q + COL_W'(1)) : rd_col_q;
    window_c  = '0;
    for (int r = 0; r < 3; r++) begin
      window_c[(8 - 3*r)*PIX_W +: PIX_W] =
        left_ok ? line_mem[rd_line_q + LINE_W'(r)][left_idx] : '0;
      window_c[(7 - 3*r)*PIX_W +: PIX_W] = line_mem[rd_line_q + LINE_W'(r)][rd_col_q];
      window_c[(6 - 3*r)*PIX_W +: PIX_W] =
        right_ok ? line_mem[rd_line_q + LINE_W'(r)][right_idx] : '0;
    end
  end

  // Read FSM; the held window lives in win_data_q, so the line frees at issue time.
  always_comb begin
    state_d      = state_q;
    rd_col_d     = rd_col_q;
    rd_line_d    = rd_line_q;
    line_done_rd = 1'b0;
    win_data_d   = win_data_q;
    win_valid_d  = win_valid_q && !i_out_ready;
    intr_d       = 1'b0;
    advance      = !win_valid_q || i_out_ready;
    case (state_q)
      S_IDLE: begin
        if (filled_q >= CNT_W'(3)) begin
          state_d  = S_READ;
          rd_col_d = '0;
        end
      end
      S_READ: begin
        if (advance) begin
          win_data_d  = window_c;
          win_valid_d = 1'b1;
          if (rd_col_q == LAST_COL) begin
            rd_col_d     = '0;
            rd_line_d    = rd_line_q + LINE_W'(1);
            line_done_rd = 1'b1;
            intr_d       = 1'b1;
            // Post-update fill is filled_q + line_done_wr - 1; stay in READ when that is >= 3.
            if ((filled_q + CNT_W'(line_done_wr)) < CNT_W'(NUM_LINES)) begin
              state_d = S_IDLE;
            end
          end else begin
            rd_col_d = rd_col_q + COL_W'(1);
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    filled_d = filled_q;
    if (line_done_wr && !line_done_rd) begin
      filled_d = filled_q + CNT_W'(1);
    end else if (!line_done_wr && line_done_rd) begin
      filled_d = filled_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      wr_col_q    <= '0;
      wr_line_q   <= '0;
      rd_col_q    <= '0;
      rd_line_q   <= '0;
      filled_q    <= '0;
      win_data_q  <= '0;
      win_valid_q <= 1'b0;
      intr_q      <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      wr_col_q    <= wr_col_d;
      wr_line_q   <= wr_line_d;
      rd_col_q    <= rd_col_d;
      rd_line_q   <= rd_line_d;
      filled_q    <= filled_d;
      win_data_q  <= win_data_d;
      win_valid_q <= win_valid_d;
      intr_q      <= intr_d;
      overflow_q  <= overflow_d;
    end
  end

  assign o_window_data  = win_data_q;
  assign o_window_valid = win_valid_q;
  assign o_intr         = intr_q;
  assign o_overflow     = overflow_q;

endmodule

// File: tb/tb_rgb_line_window_ctrl.sv
// Directed bench for rgb_line_window_ctrl: hand-computed window table plus scoreboarded
// multi-line sequences covering backpressure, overflow, back-to-back rows and mid-row reset.
module tb_rgb_line_window_ctrl;

  localparam int W  = 416;
  localparam int PW = 24;
  localparam int WW = 9 * PW;

  typedef struct {
    int            idx;
    logic [WW-1:0] win;
  } vec_t;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [PW-1:0] i_pixel_data = '0;
  logic          i_pixel_valid = 1'b0;
  logic [WW-1:0] o_window_data;
  logic          o_window_valid;
  logic          i_out_ready = 1'b0;
  logic          o_intr;
  logic          o_overflow;

  rgb_line_window_ctrl dut (
    .clk            (clk),
    .reset          (reset),
    .i_pixel_data   (i_pixel_data),
    .i_pixel_valid  (i_pixel_valid),
    .o_window_data  (o_window_data),
    .o_window_valid (o_window_valid),
    .i_out_ready    (i_out_ready),
    .o_intr         (o_intr),
    .o_overflow     (o_overflow)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int passed = 0;

  int   line_base, src_line, src_col, lines_req, feed_limit;
  bit   intr_feeds, log_en, gap_en;
  int   ready_mode;
  logic rdy_t;
  int   acc_cnt, exp_line, exp_col, intr_cnt, gap_cnt;
  logic [WW-1:0] win_log [W];
  vec_t vecs [4];

  function automatic logic [PW-1:0] pix(input int line, input int col);
    logic [7:0]  l;
    logic [15:0] c;
    l = 8'(line);
    c = 16'(col);
    return {l, c};
  endfunction

  function automatic logic [WW-1:0] exp_win(input int top, input int col);
    logic [WW-1:0] w;
    int c;
    w = '0;
    for (int r = 0; r < 3; r++) begin
      for (int p = 0; p < 3; p++) begin
        c = col - 1 + p;
        if (c >= 0 && c < W) w[(8 - (3*r + p))*PW +: PW] = pix(top + r, c);
      end
    end
    return w;
  endfunction

  task automatic check(input string name, input logic [WW-1:0] act, input logic [WW-1:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h want %0h", name, act, exp);
  endtask

  // One clock: drive feeder/ready, score the current outputs, then advance to #1 after the edge.
  task automatic tick();
    logic pv, rdy;
    pv = (src_line - line_base) < lines_req;
    case (ready_mode)
      0:       rdy = 1'b1;
      1:       rdy = 1'b0;
      default: begin rdy_t = ~rdy_t; rdy = rdy_t; end
    endcase
    i_pixel_valid = pv;
    i_pixel_data  = pv ? pix(src_line, src_col) : '0;
    i_out_ready   = rdy;
    if (o_intr) begin
      intr_cnt++;
      check("intr_with_last_window", WW'({o_window_valid, exp_col == W - 1}), WW'(2'b11));
      if (intr_feeds && lines_req < feed_limit) lines_req++;
    end
    if (o_window_valid) check("window_data", o_window_data, exp_win(exp_line, exp_col));
    else if (gap_en && acc_cnt > 0) gap_cnt++;
    if (o_window_valid && rdy) begin
      if (log_en && acc_cnt < W) win_log[acc_cnt] = o_window_data;
      acc_cnt++;
      exp_col++;
      if (exp_col == W) begin
        exp_col = 0;
        exp_line++;
      end
    end
    if (pv) begin
      src_col++;
      if (src_col == W) begin
        src_col = 0;
        src_line++;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic run_until_acc(input int target, input int max_cycles, input string name);
    int n;
    n = 0;
    while (acc_cnt < target && n < max_cycles) begin
      tick();
      n++;
    end
    check(name, WW'(acc_cnt), WW'(target));
  endtask

  task automatic idle_ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic do_reset(input int base);
    reset         = 1'b1;
    i_pixel_valid = 1'b0;
    i_pixel_data  = '0;
    i_out_ready   = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset      = 1'b0;
    line_base  = base;
    src_line   = base;
    src_col    = 0;
    exp_line   = base;
    exp_col    = 0;
    lines_req  = 0;
    feed_limit = 0;
    intr_feeds = 1'b0;
    log_en     = 1'b0;
    gap_en     = 1'b0;
    ready_mode = 0;
    rdy_t      = 1'b0;
    acc_cnt    = 0;
    intr_cnt   = 0;
    gap_cnt    = 0;
    check("reset_ctrl_outputs", WW'({o_window_valid, o_intr, o_overflow}), '0);
    check("reset_window_data", o_window_data, '0);
  endtask

  initial begin
    #3ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vecs[0] = '{idx: 0,   win: {24'h000000, 24'h000000, 24'h000001,
                                24'h000000, 24'h010000, 24'h010001,
                                24'h000000, 24'h020000, 24'h020001}};
    vecs[1] = '{idx: 1,   win: {24'h000000, 24'h000001, 24'h000002,
                                24'h010000, 24'h010001, 24'h010002,
                                24'h020000, 24'h020001, 24'h020002}};
    vecs[2] = '{idx: 414, win: {24'h00019d, 24'h00019e, 24'h00019f,
                                24'h01019d, 24'h01019e, 24'h01019f,
                                24'h02019d, 24'h02019e, 24'h02019f}};
    vecs[3] = '{idx: 415, win: {24'h00019e, 24'h00019f, 24'h000000,
                                24'h01019e, 24'h01019f, 24'h000000,
                                24'h02019e, 24'h02019f, 24'h000000}};

    // Three lines, ready held high: one full row with padded edges.
    do_reset(0);
    lines_req = 3;
    log_en    = 1'b1;
    run_until_acc(W, 3000, "t1_row_windows");
    idle_ticks(20);
    log_en = 1'b0;
    check("t1_no_extra_windows", WW'(acc_cnt), WW'(W));
    check("t1_intr_count", WW'(intr_cnt), WW'(1));
    check("t1_valid_dropped", WW'(o_window_valid), '0);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("t1_table_col%0d", vecs[i].idx), win_log[vecs[i].idx], vecs[i].win);
    end

    // Feeder flow: 4 lines up front, one more per o_intr, 12 lines -> 10 rows.
    do_reset(0);
    intr_feeds = 1'b1;
    feed_limit = 12;
    lines_req  = 4;
    run_until_acc(10 * W, 9000, "t2_all_rows");
    idle_ticks(20);
    check("t2_window_total", WW'(acc_cnt), WW'(10 * W));
    check("t2_intr_count", WW'(intr_cnt), WW'(10));
    check("t2_lines_sent", WW'(src_line), WW'(12));
    check("t2_no_overflow", WW'(o_overflow), '0);

    // ready low, 5 lines written: 4 stored, 5th dropped, first window held.
    do_reset(0);
    ready_mode = 1;
    lines_req  = 5;
    while ((src_line * W + src_col) < 4 * W) tick();
    check("t3_no_overflow_yet", WW'(o_overflow), '0);
    check("t3_window_held", WW'(o_window_valid), WW'(1));
    tick();
    check("t3_overflow_first_drop", WW'(o_overflow), WW'(1));
    idle_ticks(W + 5);
    check("t3_overflow_sticky", WW'(o_overflow), WW'(1));
    check("t3_none_accepted", WW'(acc_cnt), '0);
    ready_mode = 0;
    run_until_acc(2 * W, 3000, "t3_stored_rows");
    idle_ticks(20);
    check("t3_only_two_rows", WW'(acc_cnt), WW'(2 * W));
    check("t3_intr_count", WW'(intr_cnt), WW'(2));

    // ready toggling every cycle: every window exactly once, in order.
    do_reset(0);
    ready_mode = 2;
    lines_req  = 3;
    run_until_acc(W, 4000, "t4_toggle_row");
    idle_ticks(20);
    check("t4_no_extra_windows", WW'(acc_cnt), WW'(W));
    check("t4_intr_count", WW'(intr_cnt), WW'(1));

    // Last pixel of line 3 lands on the same edge as the row-0 last issue: no IDLE gap.
    do_reset(0);
    lines_req = 3;
    while (src_line < 3) tick();
    tick();
    lines_req = 4;
    gap_en    = 1'b1;
    run_until_acc(2 * W, 3000, "t5_two_rows");
    gap_en = 1'b0;
    check("t5_no_gap_between_rows", WW'(gap_cnt), '0);
    check("t5_intr_count", WW'(intr_cnt), WW'(2));

    // Reset mid row 1, then refill from a fresh line numbering.
    do_reset(0);
    intr_feeds = 1'b1;
    feed_limit = 100;
    lines_req  = 4;
    run_until_acc(W + 200, 3000, "t6_reach_col200");
    reset         = 1'b1;
    i_pixel_valid = 1'b0;
    #1;
    check("t6_async_ctrl_zero", WW'({o_window_valid, o_intr, o_overflow}), '0);
    check("t6_async_data_zero", o_window_data, '0);
    do_reset(100);
    lines_req = 3;
    log_en    = 1'b1;
    run_until_acc(W, 3000, "t6_refill_row");
    check("t6_first_window", win_log[0],
          {24'h000000, 24'h640000, 24'h640001,
           24'h000000, 24'h650000, 24'h650001,
           24'h000000, 24'h660000, 24'h660001});
    idle_ticks(10);
    check("t6_intr_count", WW'(intr_cnt), WW'(1));

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
